// File: rtl/nv_ram_fifo_ctl_60x21.sv
// Valid/ready FIFO controller sequencing an external 60x21 two-port RAM with
// registered read address, registered output and output bypass mux (61-entry FIFO).
module nv_ram_fifo_ctl_60x21 #(
    parameter int unsigned DEPTH = 60,
    parameter int unsigned WIDTH = 21,
    parameter int unsigned AW    = 6
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             wr_pvld,
    output logic             wr_prdy,
    input  logic [WIDTH-1:0] wr_pd,
    output logic             rd_pvld,
    input  logic             rd_prdy,
    output logic [WIDTH-1:0] rd_pd,
    output logic             ram_we,
    output logic [AW-1:0]    ram_wa,
    output logic [WIDTH-1:0] ram_di,
    output logic             ram_re,
    output logic [AW-1:0]    ram_ra,
    output logic             ram_ore,
    output logic             ram_byp_sel,
    output logic [WIDTH-1:0] ram_dbyp,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [6:0]       fifo_cnt,
    output logic             idle
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [CW-1:0] unread_q, unread_d;
    logic [CW-1:0] used_q, used_d;
    logic          s1_vld_q, s1_vld_d;
    logic          out_vld_q, out_vld_d;

    logic push, pop, ofree, byp, wr, cap, rd;

    always_comb begin
        // wr_prdy depends on registered occupancy only, never on rd_prdy
        wr_prdy     = (used_q < CW'(DEPTH));
        rd_pvld     = out_vld_q;
        push        = wr_pvld & wr_prdy;
        pop         = out_vld_q & rd_prdy;
        ofree       = ~out_vld_q | rd_prdy;
        byp         = push & (unread_q == '0) & ~s1_vld_q & ofree;
        wr          = push & ~byp;
        cap         = s1_vld_q & ofree & ~byp;
        rd          = (unread_q != '0) & (~s1_vld_q | cap);

        ram_we      = wr;
        ram_wa      = wr ? wr_ptr_q : wa_q;
        ram_di      = wr_pd;
        ram_re      = rd;
        ram_ra      = rd ? rd_ptr_q : ra_q;
        ram_ore     = byp | cap;
        ram_byp_sel = byp;
        ram_dbyp    = wr_pd;
        rd_pd       = ram_dout;

        fifo_cnt    = 7'(used_q) + 7'(out_vld_q);
        idle        = (fifo_cnt == '0) & ~push;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wa_d      = wa_q;
        ra_d      = ra_q;
        unread_d  = unread_q + CW'(wr) - CW'(rd);
        used_d    = used_q + CW'(wr) - CW'(cap);
        s1_vld_d  = rd ? 1'b1 : (cap ? 1'b0 : s1_vld_q);
        out_vld_d = ram_ore ? 1'b1 : (pop ? 1'b0 : out_vld_q);
        if (wr) begin
            wa_d     = wr_ptr_q;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd) begin
            ra_d     = rd_ptr_q;
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wa_q      <= '0;
            ra_q      <= '0;
            unread_q  <= '0;
            used_q    <= '0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wa_q      <= wa_d;
            ra_q      <= ra_d;
            unread_q  <= unread_d;
            used_q    <= used_d;
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_nv_ram_fifo_ctl_60x21.sv
// Bench for nv_ram_fifo_ctl_60x21: behavioural RAM, data scoreboard, a directed
// vector table and hand-written corner sequences.
module tb_nv_ram_fifo_ctl_60x21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_pvld = 1'b0, rd_prdy = 1'b0;
    logic        wr_prdy, rd_pvld;
    logic [20:0] wr_pd = '0, rd_pd, ram_di, ram_dbyp;
    logic [20:0] ram_dout = '0;
    logic        ram_we, ram_re, ram_ore, ram_byp_sel, idle;
    logic [5:0]  ram_wa, ram_ra;
    logic [6:0]  fifo_cnt;

    always #5 clk = ~clk;

    nv_ram_fifo_ctl_60x21 #(.DEPTH(60), .WIDTH(21), .AW(6)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n),
        .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
        .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
        .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
        .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
        .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp), .ram_dout(ram_dout),
        .fifo_cnt(fifo_cnt), .idle(idle)
    );

    // Behavioural two-port RAM: latched read address, registered output, bypass mux
    logic [20:0] mem [60];
    logic [5:0]  ra_lat_m = '0;
    always @(posedge clk) begin
        if (ram_we && ram_wa < 6'd60) mem[ram_wa] <= ram_di;
        if (ram_re) ra_lat_m <= ram_ra;
        if (ram_ore) ram_dout <= ram_byp_sel ? ram_dbyp : mem[ra_lat_m];
    end

    int          checks = 0, errors = 0;
    logic [20:0] sbq [$];
    bit          pend [60];
    int          exp_wa = 0, exp_ra = 0, lat_ra = 0, wr_wraps = 0, pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        sbq.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        exp_wa = 0; exp_ra = 0; lat_ra = 0;
    endtask

    task automatic drive_and_check(input logic wv, input logic rr, input logic [20:0] pd);
        logic [20:0] e;
        wr_pvld = wv; rd_prdy = rr; wr_pd = pd;
        @(negedge clk);
        chk("fifo_cnt", 32'(fifo_cnt), 32'(sbq.size()));
        chk("cnt_max", 32'(fifo_cnt <= 7'd61), 32'd1);
        chk("idle", 32'(idle), 32'(sbq.size() == 0 && !(wr_pvld && wr_prdy)));
        if (ram_byp_sel) chk("byp_we", 32'(ram_we), 32'd0);
        if (ram_ore && !ram_byp_sel) pend[lat_ra] = 1'b0;
        if (ram_we) begin
            chk("ram_wa", 32'(ram_wa), 32'(exp_wa));
            chk("overwrite", 32'(pend[exp_wa]), 32'd0);
            pend[exp_wa] = 1'b1;
            if (exp_wa == 59) begin exp_wa = 0; wr_wraps++; end
            else exp_wa++;
        end
        if (ram_re) begin
            chk("ram_ra", 32'(ram_ra), 32'(exp_ra));
            lat_ra = exp_ra;
            exp_ra = (exp_ra == 59) ? 0 : exp_ra + 1;
        end
        if (rd_pvld && rd_prdy) begin
            pops++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL pop_empty actual=pop expected=no_pop");
            end else begin
                e = sbq.pop_front();
                if (rd_pd !== e) begin
                    errors++;
                    $display("FAIL rd_pd actual=%0h expected=%0h", rd_pd, e);
                end
            end
        end
        if (wr_pvld && wr_prdy) sbq.push_back(wr_pd);
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic wv, input logic rr, input logic [20:0] pd);
        drive_and_check(wv, rr, pd);
        finish_cycle();
    endtask

    task automatic do_reset();
        wr_pvld = 1'b0; rd_prdy = 1'b0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        finish_cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (sbq.size() != 0 || fifo_cnt != 0); i++) step(1'b0, 1'b1, '0);
        drive_and_check(1'b0, 1'b0, '0);
        chk("drain_cnt", 32'(fifo_cnt), 32'd0);
        finish_cycle();
    endtask

    typedef struct {
        logic        wv, rr;
        logic [20:0] pd;
        logic        we, re, ore, bsel, rdv, wrdy, idl;
        logic [6:0]  cnt;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int acc;
        tbl[0] = '{1'b1, 1'b1, 21'h1ABCD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0};
        tbl[1] = '{1'b0, 1'b1, 21'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1};
        tbl[2] = '{1'b1, 1'b0, 21'h11,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0};
        tbl[3] = '{1'b1, 1'b0, 21'h22,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1};
        tbl[4] = '{1'b1, 1'b0, 21'h33,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd2};
        tbl[5] = '{1'b0, 1'b0, 21'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd3};
        tbl[6] = '{1'b0, 1'b1, 21'h0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd3};
        tbl[7] = '{1'b0, 1'b1, 21'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd2};
        tbl[8] = '{1'b0, 1'b1, 21'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1};
        tbl[9] = '{1'b0, 1'b0, 21'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0};

        #3;
        chk("rst_rd_pvld", 32'(rd_pvld), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_wr_prdy", 32'(wr_prdy), 32'd1);
        chk("rst_ram_en", 32'({ram_we, ram_re, ram_ore, ram_byp_sel}), 32'd0);
        do_reset();

        // Directed vector table: bypass, normal write, stalls and drain
        for (int i = 0; i < 10; i++) begin
            drive_and_check(tbl[i].wv, tbl[i].rr, tbl[i].pd);
            chk($sformatf("t%0d_we", i), 32'(ram_we), 32'(tbl[i].we));
            chk($sformatf("t%0d_re", i), 32'(ram_re), 32'(tbl[i].re));
            chk($sformatf("t%0d_ore", i), 32'(ram_ore), 32'(tbl[i].ore));
            chk($sformatf("t%0d_bsel", i), 32'(ram_byp_sel), 32'(tbl[i].bsel));
            chk($sformatf("t%0d_rdv", i), 32'(rd_pvld), 32'(tbl[i].rdv));
            chk($sformatf("t%0d_wrdy", i), 32'(wr_prdy), 32'(tbl[i].wrdy));
            chk($sformatf("t%0d_idle", i), 32'(idle), 32'(tbl[i].idl));
            chk($sformatf("t%0d_cnt", i), 32'(fifo_cnt), 32'(tbl[i].cnt));
            finish_cycle();
        end

        // Fill to 61 with output blocked, then push+pop at full, then drain
        do_reset();
        acc = 0;
        for (int i = 0; i <= 70; i++) begin
            drive_and_check(1'b1, 1'b0, 21'(i));
            if (wr_prdy) acc++;
            finish_cycle();
        end
        chk("fill_accepts", 32'(acc), 32'd61);
        drive_and_check(1'b1, 1'b1, 21'h7777);
        chk("full_cnt", 32'(fifo_cnt), 32'd61);
        chk("full_wr_prdy", 32'(wr_prdy), 32'd0);
        chk("full_cap_ore", 32'(ram_ore), 32'd1);
        chk("full_cap_re", 32'(ram_re), 32'd1);
        finish_cycle();
        drive_and_check(1'b1, 1'b0, 21'h7778);
        chk("after_cap_wr_prdy", 32'(wr_prdy), 32'd1);
        finish_cycle();
        pops = 0;
        drain();
        chk("drain_pops", 32'(pops), 32'd61);

        // Output blocked with stage 1 loaded: read address must hold
        do_reset();
        step(1'b1, 1'b0, 21'hA);
        step(1'b1, 1'b0, 21'hB);
        step(1'b1, 1'b0, 21'hC);
        for (int i = 0; i < 3; i++) begin
            drive_and_check(1'b0, 1'b0, '0);
            chk("blk_re", 32'(ram_re), 32'd0);
            chk("blk_ore", 32'(ram_ore), 32'd0);
            chk("blk_ra", 32'(ram_ra), 32'd0);
            finish_cycle();
        end
        drive_and_check(1'b0, 1'b1, '0);
        chk("unblk_re", 32'(ram_re), 32'd1);
        chk("unblk_ore", 32'(ram_ore), 32'd1);
        chk("unblk_ra", 32'(ram_ra), 32'd1);
        finish_cycle();
        drain();

        // Random traffic with pointer wrap
        do_reset();
        wr_wraps = 0;
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 21'($urandom));
        chk("wr_wraps_ge2", 32'(wr_wraps >= 2), 32'd1);
        drain();

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 21'(100 + i));
        wr_pvld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_pvld", 32'(rd_pvld), 32'd0);
        chk("arst_cnt", 32'(fifo_cnt), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_wr_prdy", 32'(wr_prdy), 32'd1);
        model_clear();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        finish_cycle();
        drive_and_check(1'b1, 1'b1, 21'h55);
        chk("post_rst_bsel", 32'(ram_byp_sel), 32'd1);
        chk("post_rst_ore", 32'(ram_ore), 32'd1);
        chk("post_rst_we", 32'(ram_we), 32'd0);
        finish_cycle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
